// File: rtl/instr_queue_if.sv
// Predictor-to-decode handshake bundle for instr_queue, plus the shared
// instruction record type it carries.

package instr_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ptaken;
        logic [31:0] ptarget;
    } ir_reg_t;

    localparam ir_reg_t NULL_IR_REG = '0;

endpackage

interface instr_queue_if;

    logic [1:0]               pdt_valid_i;
    instr_queue_pkg::ir_reg_t pdt_instr0_i;
    instr_queue_pkg::ir_reg_t pdt_instr1_i;
    logic [1:0]               ds_rdy_o;

    logic [1:0]               ir_valid_o;
    instr_queue_pkg::ir_reg_t ir_instr0_o;
    instr_queue_pkg::ir_reg_t ir_instr1_o;
    logic [1:0]               ir_rdy_i;

    // master: predictor/decode side; slave: the queue itself
    modport master (
        output pdt_valid_i, pdt_instr0_i, pdt_instr1_i, ir_rdy_i,
        input  ds_rdy_o, ir_valid_o, ir_instr0_o, ir_instr1_o
    );

    modport slave (
        input  pdt_valid_i, pdt_instr0_i, pdt_instr1_i, ir_rdy_i,
        output ds_rdy_o, ir_valid_o, ir_instr0_o, ir_instr1_o
    );

endinterface

// File: rtl/instr_queue.sv
// Two-wide in-order instruction queue between branch predictor and decode.
// Up to two enqueues and two dequeues per cycle; flushed on EX redirect.

module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    instr_queue_if.slave           iq,
    output logic [$clog2(Depth):0] occupancy_o
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    ir_reg_t mem_q [Depth];
    ir_reg_t mem_d [Depth];
    ptr_t    wr_ptr_q, wr_ptr_d;
    ptr_t    rd_ptr_q, rd_ptr_d;
    cnt_t    count_q,  count_d;

    logic       blocked;
    cnt_t       free;
    logic [1:0] ds_rdy;
    logic [1:0] ir_valid;
    logic       acc0, acc1;
    logic       deq0, deq1;
    ptr_t       wr_ptr_p1;
    ptr_t       rd_ptr_p1;

    // Handshake status depends on registered count only, so there is
    // no combinational path from this cycle's dequeue to ds_rdy.
    always_comb begin
        blocked  = rst_i | flush_i;
        free     = cnt_t'(Depth) - count_q;
        ds_rdy   = '0;
        ir_valid = '0;
        if (!blocked) begin
            ds_rdy[0]   = (free    >= cnt_t'(1));
            ds_rdy[1]   = (free    >= cnt_t'(2));
            ir_valid[0] = (count_q >= cnt_t'(1));
            ir_valid[1] = (count_q >= cnt_t'(2));
        end
    end

    always_comb begin
        acc0 = iq.pdt_valid_i[0] & ds_rdy[0];
        acc1 = acc0 & iq.pdt_valid_i[1] & ds_rdy[1];
        deq0 = ir_valid[0] & iq.ir_rdy_i[0];
        deq1 = deq0 & ir_valid[1] & iq.ir_rdy_i[1];
    end

    assign wr_ptr_p1 = wr_ptr_q + ptr_t'(1);
    assign rd_ptr_p1 = rd_ptr_q + ptr_t'(1);

    always_comb begin
        mem_d = mem_q;
        if (acc0) begin
            mem_d[wr_ptr_q] = iq.pdt_instr0_i;
        end
        if (acc1) begin
            mem_d[wr_ptr_p1] = iq.pdt_instr1_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + ptr_t'(acc0) + ptr_t'(acc1);
        rd_ptr_d = rd_ptr_q + ptr_t'(deq0) + ptr_t'(deq1);
        count_d  = count_q + cnt_t'(acc0) + cnt_t'(acc1)
                           - cnt_t'(deq0) - cnt_t'(deq1);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; validity is tracked purely by count_q.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        iq.ds_rdy_o    = ds_rdy;
        iq.ir_valid_o  = ir_valid;
        iq.ir_instr0_o = ir_valid[0] ? mem_q[rd_ptr_q]  : NULL_IR_REG;
        iq.ir_instr1_o = ir_valid[1] ? mem_q[rd_ptr_p1] : NULL_IR_REG;
    end

    assign occupancy_o = count_q;

    // A lone younger slot has no older partner to keep ordering; it is dropped.
    a_no_lone_slot1: assert property (
        @(posedge clk_i) disable iff (rst_i) iq.pdt_valid_i != 2'b10
    ) else $warning("instr_queue: pdt_valid_i=2'b10 is illegal, nothing enqueued");

endmodule

// File: tb/tb_instr_queue.sv
// Randomized and directed bench for instr_queue; a queue-based reference model
// feeds an expected-output scoreboard drained by an independent monitor.

module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] occupancy;

    instr_queue_if bus ();

    instr_queue #(.Depth(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .iq          (bus),
        .occupancy_o (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_vec = 0;
    int      n_err = 0;
    ir_reg_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ir_reg_t mk(input logic [31:0] pc);
        ir_reg_t r;
        r.valid   = 1'b1;
        r.pc      = pc;
        r.instr   = $urandom;
        r.ptaken  = 1'($urandom_range(0, 1));
        r.ptarget = $urandom;
        return r;
    endfunction

    // Monitor: compares DUT outputs against the model and retires consumed entries.
    initial begin
        int         sz;
        int         fr;
        logic       blk;
        logic [1:0] ev, er;
        logic       d0, d1;
        ir_reg_t    e0, e1;
        forever begin
            @(negedge clk);
            sz  = exp_q.size();
            fr  = DEPTH - sz;
            blk = rst | flush;
            ev  = blk ? 2'b00 : {sz >= 2, sz >= 1};
            er  = blk ? 2'b00 : {fr >= 2, fr >= 1};
            chk("ir_valid", 128'(bus.ir_valid_o), 128'(ev));
            chk("ds_rdy", 128'(bus.ds_rdy_o), 128'(er));
            chk("occupancy", 128'(occupancy), 128'(sz));
            e0 = NULL_IR_REG;
            e1 = NULL_IR_REG;
            if (ev[0]) e0 = exp_q[0];
            if (ev[1]) e1 = exp_q[1];
            chk("ir_instr0", 128'(bus.ir_instr0_o), 128'(e0));
            chk("ir_instr1", 128'(bus.ir_instr1_o), 128'(e1));
            if (blk) begin
                exp_q.delete();
            end else begin
                d0 = ev[0] & bus.ir_rdy_i[0];
                d1 = d0 & ev[1] & bus.ir_rdy_i[1];
                if (d0) void'(exp_q.pop_front());
                if (d1) void'(exp_q.pop_front());
            end
        end
    end

    // Driver: applies one cycle of stimulus and queues what the queue must accept.
    task automatic step(input logic r, input logic fl, input logic [1:0] v,
                        input ir_reg_t i0, input ir_reg_t i1, input logic [1:0] rdy);
        int   fr;
        logic a0, a1;
        @(posedge clk);
        #1;
        rst              = r;
        flush            = fl;
        bus.pdt_valid_i  = v;
        bus.pdt_instr0_i = i0;
        bus.pdt_instr1_i = i1;
        bus.ir_rdy_i     = rdy;
        fr = DEPTH - exp_q.size();
        a0 = !(r | fl) && v[0] && (fr >= 1);
        a1 = a0 && v[1] && (fr >= 2);
        @(negedge clk);
        #1;
        if (a0) exp_q.push_back(i0);
        if (a1) exp_q.push_back(i1);
    endtask

    task automatic idle(input logic [1:0] rdy);
        step(1'b0, 1'b0, 2'b00, NULL_IR_REG, NULL_IR_REG, rdy);
    endtask

    initial begin
        logic [31:0] pc;
        rst              = 1'b1;
        flush            = 1'b0;
        bus.pdt_valid_i  = 2'b00;
        bus.pdt_instr0_i = NULL_IR_REG;
        bus.pdt_instr1_i = NULL_IR_REG;
        bus.ir_rdy_i     = 2'b00;

        repeat (3) step(1'b1, 1'b0, 2'b00, NULL_IR_REG, NULL_IR_REG, 2'b00);
        idle(2'b00);
        chk("rst_occ", 128'(occupancy), 128'(0));
        chk("rst_ds_rdy", 128'(bus.ds_rdy_o), 128'(2'b11));
        chk("rst_instr0", 128'(bus.ir_instr0_o), 128'(NULL_IR_REG));

        // Pair enqueue, visible one cycle later
        step(1'b0, 1'b0, 2'b11, mk(32'h100), mk(32'h104), 2'b00);
        idle(2'b00);
        chk("t1_valid", 128'(bus.ir_valid_o), 128'(2'b11));
        chk("t1_pc0", 128'(bus.ir_instr0_o.pc), 128'(32'h100));
        chk("t1_pc1", 128'(bus.ir_instr1_o.pc), 128'(32'h104));
        chk("t1_occ", 128'(occupancy), 128'(2));
        chk("t1_ds_rdy", 128'(bus.ds_rdy_o), 128'(2'b11));

        // Fill to 3 then offer a pair: only the older one fits
        step(1'b0, 1'b0, 2'b01, mk(32'h108), NULL_IR_REG, 2'b00);
        step(1'b0, 1'b0, 2'b11, mk(32'h10C), mk(32'h110), 2'b00);
        chk("t2_occ3", 128'(occupancy), 128'(3));
        chk("t2_ds_rdy01", 128'(bus.ds_rdy_o), 128'(2'b01));
        idle(2'b00);
        chk("t2_occ4", 128'(occupancy), 128'(4));
        chk("t2_ds_rdy00", 128'(bus.ds_rdy_o), 128'(2'b00));

        // Full: simultaneous offer and double dequeue, no enqueue
        step(1'b0, 1'b0, 2'b11, mk(32'h114), mk(32'h118), 2'b11);
        idle(2'b00);
        chk("t3_occ", 128'(occupancy), 128'(2));
        chk("t3_ds_rdy", 128'(bus.ds_rdy_o), 128'(2'b11));
        chk("t3_pc0", 128'(bus.ir_instr0_o.pc), 128'(32'h108));
        chk("t3_pc1", 128'(bus.ir_instr1_o.pc), 128'(32'h10C));

        // Streaming 2 in / 2 out across pointer wrap
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 2'b11, mk(32'h200 + 32'(8 * k)), mk(32'h204 + 32'(8 * k)), 2'b11);
            chk("t4_occ", 128'(occupancy), 128'(2));
        end
        idle(2'b11);
        idle(2'b00);
        chk("t4_drained", 128'(occupancy), 128'(0));

        // Flush with simultaneous enqueue
        step(1'b0, 1'b0, 2'b11, mk(32'h300), mk(32'h304), 2'b00);
        step(1'b0, 1'b0, 2'b01, mk(32'h308), NULL_IR_REG, 2'b00);
        step(1'b0, 1'b1, 2'b11, mk(32'h30C), mk(32'h310), 2'b11);
        chk("t5_flush_valid", 128'(bus.ir_valid_o), 128'(2'b00));
        chk("t5_flush_ds_rdy", 128'(bus.ds_rdy_o), 128'(2'b00));
        idle(2'b00);
        chk("t5_occ", 128'(occupancy), 128'(0));
        chk("t5_valid", 128'(bus.ir_valid_o), 128'(2'b00));
        chk("t5_instr0", 128'(bus.ir_instr0_o), 128'(NULL_IR_REG));
        chk("t5_instr1", 128'(bus.ir_instr1_o), 128'(NULL_IR_REG));

        // Lone slot-1 ready dequeues nothing; lone slot-1 valid enqueues nothing
        step(1'b0, 1'b0, 2'b11, mk(32'h400), mk(32'h404), 2'b00);
        step(1'b0, 1'b0, 2'b00, NULL_IR_REG, NULL_IR_REG, 2'b10);
        step(1'b0, 1'b0, 2'b10, mk(32'h408), mk(32'h40C), 2'b00);
        chk("t6_rdy10_occ", 128'(occupancy), 128'(2));
        idle(2'b00);
        chk("t6_v10_occ", 128'(occupancy), 128'(2));
        chk("t6_pc0", 128'(bus.ir_instr0_o.pc), 128'(32'h400));
        idle(2'b11);

        // Randomized traffic with occasional flush and reset
        pc = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] v;
            logic       r, fl;
            ir_reg_t    i0, i1;
            case ($urandom_range(0, 2))
                0:       v = 2'b00;
                1:       v = 2'b01;
                default: v = 2'b11;
            endcase
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 31) == 0);
            i0 = mk(pc);
            i1 = mk(pc + 32'd4);
            pc = pc + 32'd8;
            step(r, fl, v, i0, i1, 2'($urandom));
        end
        idle(2'b00);
        idle(2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
